// File: rtl/datapath_stream_source.sv
// Frame-based 8-bit test pattern source with valid/sof/busy handshake.
// Optional STREAM_SOURCE_CHECKSUM_EN adds a per-frame 16-bit sum of accepted beats.
module datapath_stream_source #(
  parameter int          FRAME_LEN  = 24,
  parameter int          BLOCK_LEN  = 3,
  parameter int          GAP_CYCLES = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  const_val,
  input  logic [7:0]  num_frames,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        sof_out,
  input  logic        busy_in,
  output logic        active,
  output logic        done
`ifdef STREAM_SOURCE_CHECKSUM_EN
  ,
  output logic [15:0] checksum_out,
  output logic        checksum_valid
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [15:0] BLK_LAST = 16'(BLOCK_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic        blk_hi_q, blk_hi_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  frames_left_q, frames_left_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  const_q, const_d;

  logic        accept;
  logic        last_beat;
  logic        last_frame;
  logic        lfsr_fb;
  logic [7:0]  sample;

  assign accept     = (state_q == SEND) && !busy_in;
  assign last_beat  = (idx_q == LAST_IDX);
  assign last_frame = (frames_left_q == 8'd1);
  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_frames == 8'd0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (accept && last_beat) begin
          if (last_frame) begin
            state_d = DONE;
          end else begin
            state_d = (GAP_CYCLES == 0) ? SEND : GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern generator for the beat currently presented
  always_comb begin
    sample = 8'h00;
    case (mode_q)
      2'd0:    sample = const_q;
      2'd1:    sample = idx_q[7:0];
      2'd2:    sample = blk_hi_q ? 8'hFF : 8'h00;
      default: sample = lfsr_q;
    endcase
  end

  // Output logic: everything is derived from registered state, so it is
  // naturally stable while busy_in stalls the counters.
  always_comb begin
    valid_out = (state_q == SEND);
    sof_out   = (state_q == SEND) && (idx_q == 16'd0);
    active    = (state_q == SEND) || (state_q == GAP);
    done      = (state_q == DONE);
    data_out  = (state_q == SEND) ? sample : 8'h00;
  end

  always_comb begin
    idx_d         = idx_q;
    blk_cnt_d     = blk_cnt_q;
    blk_hi_d      = blk_hi_q;
    gap_cnt_d     = gap_cnt_q;
    frames_left_d = frames_left_q;
    lfsr_d        = lfsr_q;
    mode_d        = mode_q;
    const_d       = const_q;
    if (state_q == IDLE && start) begin
      mode_d        = mode;
      const_d       = const_val;
      frames_left_d = num_frames;
      idx_d         = 16'd0;
      blk_cnt_d     = 16'd0;
      blk_hi_d      = 1'b0;
      gap_cnt_d     = 16'd0;
      lfsr_d        = LFSR_SEED;
    end
    if (accept) begin
      lfsr_d = {lfsr_q[6:0], lfsr_fb};
      if (last_beat) begin
        idx_d         = 16'd0;
        blk_cnt_d     = 16'd0;
        blk_hi_d      = 1'b0;
        gap_cnt_d     = 16'd0;
        frames_left_d = frames_left_q - 8'd1;
      end else begin
        idx_d = idx_q + 16'd1;
        if (blk_cnt_q == BLK_LAST) begin
          blk_cnt_d = 16'd0;
          blk_hi_d  = ~blk_hi_q;
        end else begin
          blk_cnt_d = blk_cnt_q + 16'd1;
        end
      end
    end
    if (state_q == GAP) begin
      gap_cnt_d = gap_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q         <= 16'd0;
      blk_cnt_q     <= 16'd0;
      blk_hi_q      <= 1'b0;
      gap_cnt_q     <= 16'd0;
      frames_left_q <= 8'd0;
      lfsr_q        <= LFSR_SEED;
      mode_q        <= 2'd0;
      const_q       <= 8'd0;
    end else begin
      idx_q         <= idx_d;
      blk_cnt_q     <= blk_cnt_d;
      blk_hi_q      <= blk_hi_d;
      gap_cnt_q     <= gap_cnt_d;
      frames_left_q <= frames_left_d;
      lfsr_q        <= lfsr_d;
      mode_q        <= mode_d;
      const_q       <= const_d;
    end
  end

`ifdef STREAM_SOURCE_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic        ck_valid_q, ck_valid_d;

  // The sof beat restarts the sum, so a stale total never leaks into a new frame.
  always_comb begin
    sum_d      = sum_q;
    ck_valid_d = 1'b0;
    if (accept) begin
      sum_d      = (sof_out ? 16'd0 : sum_q) + {8'd0, data_out};
      ck_valid_d = last_beat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q      <= 16'd0;
      ck_valid_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      ck_valid_q <= ck_valid_d;
    end
  end

  assign checksum_out   = sum_q;
  assign checksum_valid = ck_valid_q;
`endif

endmodule

// File: tb/tb_datapath_stream_source.sv
// Randomized self-checking bench for datapath_stream_source; expected beats come
// from a frame/sample-index reference model. Define STREAM_SOURCE_CHECKSUM_EN to test sums.
module tb_datapath_stream_source;

  localparam int FRAME_LEN  = 24;
  localparam int BLOCK_LEN  = 3;
  localparam int GAP_CYCLES = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] const_val = 8'd0;
  logic [7:0] num_frames = 8'd0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       sof_out;
  logic       busy_in = 1'b0;
  logic       active;
  logic       done;
`ifdef STREAM_SOURCE_CHECKSUM_EN
  logic [15:0] checksum_out;
  logic        checksum_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];  // {sof, data}

  always #5 i_clk = ~i_clk;

  datapath_stream_source #(
    .FRAME_LEN(FRAME_LEN), .BLOCK_LEN(BLOCK_LEN),
    .GAP_CYCLES(GAP_CYCLES), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .start(start), .mode(mode),
    .const_val(const_val), .num_frames(num_frames),
    .data_out(data_out), .valid_out(valid_out), .sof_out(sof_out),
    .busy_in(busy_in), .active(active), .done(done)
`ifdef STREAM_SOURCE_CHECKSUM_EN
    , .checksum_out(checksum_out), .checksum_valid(checksum_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Reference: every frame is FRAME_LEN samples indexed 0..FRAME_LEN-1.
  task automatic build_expected(input logic [1:0] m, input logic [7:0] cv, input int nf);
    logic [7:0] lf;
    logic [7:0] d;
    int i_mod;
    lf = SEED;
    exp_q.delete();
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        i_mod = i % 256;
        case (m)
          2'd0: d = cv;
          2'd1: d = i_mod[7:0];
          2'd2: d = (((i / BLOCK_LEN) % 2) == 1) ? 8'hFF : 8'h00;
          default: begin
            d  = lf;
            lf = lfsr_step(lf);
          end
        endcase
        exp_q.push_back({(i == 0), d});
      end
    end
  endtask

  // bkind: 0 never busy, 1 random busy, 2 busy for 10 cycles at beat 5.
  // rst_at >= 0: pulse i_rst once that many beats have been accepted.
  task automatic run(input logic [1:0] m, input logic [7:0] cv, input int nf,
                     input int bkind, input int rst_at);
    int got, dones, gaps, stall, ncyc, vcount, total;
    bit finished, prev_hold, start_poked;
    logic [7:0] prev_data;
    logic prev_sof, prev_valid;
    logic [8:0] e;
    logic [15:0] run_sum, pend_sum;
    bit pend;
    build_expected(m, cv, nf);
    total = exp_q.size();
    got = 0; dones = 0; gaps = 0; stall = 0; ncyc = 0; vcount = 0;
    finished = 0; prev_hold = 0; start_poked = 0; pend = 0;
    run_sum = 16'd0; pend_sum = 16'd0;
    prev_data = 8'd0; prev_sof = 1'b0; prev_valid = 1'b0;

    @(negedge i_clk);
    mode = m; const_val = cv; num_frames = nf[7:0]; start = 1'b1; busy_in = 1'b0;
    @(negedge i_clk);
    start = 1'b0;
    mode = 2'($urandom); const_val = 8'($urandom); num_frames = 8'($urandom);

    while (!finished && ncyc < 3000) begin
      ncyc++;
      if (prev_hold) begin
        check("hold_data", data_out, prev_data);
        check("hold_sof", sof_out, prev_sof);
        check("hold_valid", valid_out, prev_valid);
      end
`ifdef STREAM_SOURCE_CHECKSUM_EN
      if (pend || checksum_valid) begin
        check("cks_valid", checksum_valid, pend);
        if (pend) check("cks_value", checksum_out, pend_sum);
      end
      pend = 0;
`endif
      if (done) begin
        dones++;
        finished = 1;
        check("done_no_valid", valid_out, 1'b0);
      end
      if (active && !valid_out) gaps++;

      if (!finished && rst_at >= 0 && got == rst_at) begin
        i_rst = 1'b1; busy_in = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_valid", valid_out, 1'b0);
        check("rst_sof", sof_out, 1'b0);
        check("rst_data", data_out, 8'h00);
        check("rst_active", active, 1'b0);
        dones = 0;
        for (int k = 0; k < 20; k++) begin
          if (done) dones++;
          if (valid_out) vcount++;
          @(negedge i_clk);
        end
        check("rst_no_done", dones, 0);
        check("rst_no_valid", vcount, 0);
        $display("run mode=%0d frames=%0d reset after %0d beats", m, nf, got);
        return;
      end

      case (bkind)
        1: busy_in = ($urandom_range(0, 3) == 0);
        2: busy_in = (got == 5 && stall < 10);
        default: busy_in = 1'b0;
      endcase
      if (busy_in && valid_out) stall++;

      if (valid_out && !busy_in) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", data_out, 8'hxx);
        end else begin
          e = exp_q.pop_front();
          check("data", data_out, e[7:0]);
          check("sof", sof_out, e[8]);
          run_sum = (e[8] ? 16'd0 : run_sum) + {8'd0, e[7:0]};
          if ((got % FRAME_LEN) == FRAME_LEN - 1) begin
            pend = 1;
            pend_sum = run_sum;
          end
        end
        got++;
      end

      // One start pulse while streaming; it must be ignored.
      if (!start_poked && got == 3 && valid_out) begin
        start = 1'b1; num_frames = 8'd0; mode = 2'($urandom);
        start_poked = 1;
      end

      prev_hold  = valid_out && busy_in;
      prev_data  = data_out;
      prev_sof   = sof_out;
      prev_valid = valid_out;
      @(negedge i_clk);
      start = 1'b0;
    end

    if (!finished) check("timeout", 0, 1);
    busy_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done) dones++;
      if (valid_out) vcount++;
      @(negedge i_clk);
    end
    check("beats", got, total);
    check("done_count", dones, 1);
    check("post_valid", vcount, 0);
    check("gap_cycles", gaps, (nf > 0) ? (nf - 1) * GAP_CYCLES : 0);
    $display("run mode=%0d const=%02h frames=%0d busy=%0d beats=%0d cycles=%0d",
             m, cv, nf, bkind, got, ncyc);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("idle_valid", valid_out, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_active", active, 1'b0);
      @(negedge i_clk);
    end
    check("idle_data", data_out, 8'h00);

    run(2'd2, 8'h00, 4, 0, -1);
    run(2'd1, 8'h00, 1, 2, -1);
    run(2'd0, 8'h3C, 0, 0, -1);
    run(2'd3, 8'h00, 2, 1, -1);
    run(2'd3, 8'h00, 1, 0, 7);
    run(2'd0, 8'hFF, 2, 1, -1);
    for (int r = 0; r < 5; r++) begin
      run(2'($urandom), 8'($urandom), $urandom_range(0, 3), 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
